// File: rtl/io_pkg.sv
// Shared definitions for the I/O port bank: default sizes, the output-channel
// state encoding and the bit-field offsets of the optional status word.
// Optional feature macro: IO_STATUS_EN (status/clr_ovr ports and overrun flags).
package io_pkg;

   localparam int NPORT_DEF   = 4;
   localparam int DW_DEF      = 8;
   localparam int SYNC_FF_DEF = 2;

   typedef enum logic [1:0] {
      OC_IDLE = 2'd0,
      OC_REQ  = 2'd1,
      OC_REL  = 2'd2
   } oc_state_e;

   // status = {overrun, out_busy, in_full}, each NPORT bits wide
   localparam int ST_FULL_LSB = 0;
   localparam int ST_BUSY_LSB = NPORT_DEF;
   localparam int ST_OVR_LSB  = 2 * NPORT_DEF;
   localparam int ST_W        = 3 * NPORT_DEF;

endpackage

// File: rtl/io_port_bank_if.sv
// Bundle of CPU-side and device-side signals of the I/O port bank.
// master: the CPU/control unit plus external devices; slave: the port bank.
// Optional feature macro: IO_STATUS_EN adds status and clr_ovr.
interface io_port_bank_if #(
   parameter int DW    = 8,
   parameter int NPORT = 4
);

   logic [NPORT-1:0]    wr_en;
   logic [DW-1:0]       wr_data;
   logic [NPORT*DW-1:0] out_data;
   logic [NPORT-1:0]    out_req;
   logic [NPORT-1:0]    out_ack;
   logic [1:0]          in_sel;
   logic                in_rd;
   logic [DW-1:0]       rd_data;
   logic [NPORT*DW-1:0] in_dev;
   logic [NPORT-1:0]    in_req;
   logic [NPORT-1:0]    in_ack;
`ifdef IO_STATUS_EN
   logic [3*NPORT-1:0]  status;
   logic                clr_ovr;

   modport master (
      output wr_en, wr_data, out_ack, in_sel, in_rd, in_dev, in_req, clr_ovr,
      input  out_data, out_req, rd_data, in_ack, status
   );

   modport slave (
      input  wr_en, wr_data, out_ack, in_sel, in_rd, in_dev, in_req, clr_ovr,
      output out_data, out_req, rd_data, in_ack, status
   );
`else
   modport master (
      output wr_en, wr_data, out_ack, in_sel, in_rd, in_dev, in_req,
      input  out_data, out_req, rd_data, in_ack
   );

   modport slave (
      input  wr_en, wr_data, out_ack, in_sel, in_rd, in_dev, in_req,
      output out_data, out_req, rd_data, in_ack
   );
`endif

endinterface

// File: rtl/io_out_chan.sv
// One output port: data register, 4-phase req/ack FSM and ack synchroniser.
// Optional feature macro: IO_STATUS_EN (busy/overrun outputs, clr_ovr input).
//
// state   | meaning
// --------+-----------------------------------------------------------
// OC_IDLE | port free, a write strobe loads out_data
// OC_REQ  | out_req high, data held, waiting for synced ack high
// OC_REL  | out_req low, waiting for synced ack low before next write
module io_out_chan
   import io_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int SYNC_FF = SYNC_FF_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          out_ack,
   output logic [DW-1:0] out_data,
   output logic          out_req
`ifdef IO_STATUS_EN
   ,
   input  logic          clr_ovr,
   output logic          busy,
   output logic          overrun
`endif
);

   oc_state_e          state, state_n;
   logic [SYNC_FF-1:0] ack_sync;
   logic               ack_s;
   logic               load;

   // Bring the asynchronous device ack into the clk domain
   always_ff @(posedge clk) begin
      if (!reset) ack_sync <= '0;
      else        ack_sync <= {ack_sync[SYNC_FF-2:0], out_ack};
   end

   assign ack_s = ack_sync[SYNC_FF-1];

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= OC_IDLE;
      else        state <= state_n;
   end

   // Next-state and load decode for the handshake sequence
   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         OC_IDLE: begin
            if (wr_en) begin
               load    = 1'b1;
               state_n = OC_REQ;
            end
         end
         OC_REQ:  if (ack_s)  state_n = OC_REL;
         OC_REL:  if (!ack_s) state_n = OC_IDLE;
         default: state_n = OC_IDLE;
      endcase
   end

   // Output data register, only loaded from IDLE so it is stable during the handshake
   always_ff @(posedge clk) begin
      if (!reset)    out_data <= '0;
      else if (load) out_data <= wr_data;
   end

   // Registered request so the device sees a glitch-free line
   always_ff @(posedge clk) begin
      if (!reset) out_req <= 1'b0;
      else        out_req <= (state_n == OC_REQ);
   end

`ifdef IO_STATUS_EN
   assign busy = (state != OC_IDLE);

   // Sticky flag for writes dropped while a handshake is in flight; a new drop wins over clear
   always_ff @(posedge clk) begin
      if (!reset)                          overrun <= 1'b0;
      else if (wr_en && state != OC_IDLE)  overrun <= 1'b1;
      else if (clr_ovr)                    overrun <= 1'b0;
   end
`endif

endmodule

// File: rtl/io_port_bank.sv
// CPU I/O peripheral endpoint: NPORT handshaked output ports and NPORT
// single-word buffered input ports with a combinational read mux.
// Optional feature macro: IO_STATUS_EN (status word and overrun clear).
module io_port_bank
   import io_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int NPORT   = NPORT_DEF,
   parameter int SYNC_FF = SYNC_FF_DEF
) (
   input logic           clk,
   input logic           reset,
   io_port_bank_if.slave bus
);

   logic [NPORT-1:0][DW-1:0] out_data_w;
   logic [NPORT-1:0]         out_req_w;
`ifdef IO_STATUS_EN
   logic [NPORT-1:0]         out_busy;
   logic [NPORT-1:0]         overrun;
`endif

   for (genvar i = 0; i < NPORT; i++) begin : g_out
      io_out_chan #(
         .DW      (DW),
         .SYNC_FF (SYNC_FF)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (bus.wr_en[i]),
         .wr_data  (bus.wr_data),
         .out_ack  (bus.out_ack[i]),
         .out_data (out_data_w[i]),
         .out_req  (out_req_w[i])
`ifdef IO_STATUS_EN
         ,
         .clr_ovr  (bus.clr_ovr),
         .busy     (out_busy[i]),
         .overrun  (overrun[i])
`endif
      );
   end

   assign bus.out_data = out_data_w;
   assign bus.out_req  = out_req_w;

   logic [NPORT-1:0] req_sync [SYNC_FF];
   logic [NPORT-1:0] req_s;
   logic [NPORT-1:0] full_q;
   logic [NPORT-1:0] ack_q;
   logic [NPORT-1:0] capture;
   logic [NPORT-1:0] rd_clr;
   logic [DW-1:0]    buf_q [NPORT];

   // Synchronise the asynchronous input requests
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_FF; k++) req_sync[k] <= '0;
      end else begin
         req_sync[0] <= bus.in_req;
         for (int k = 1; k < SYNC_FF; k++) req_sync[k] <= req_sync[k-1];
      end
   end

   assign req_s = req_sync[SYNC_FF-1];

   // A request not yet acknowledged is taken only into an empty buffer; a full
   // buffer leaves it pending, which is the backpressure to the device
   assign capture = req_s & ~ack_q & ~full_q;

   // One-hot clear of the buffer the CPU consumes this cycle
   always_comb begin
      rd_clr = '0;
      if (bus.in_rd) rd_clr[bus.in_sel] = 1'b1;
   end

   // Input buffers, full flags and ack flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q <= '0;
         ack_q  <= '0;
         for (int i = 0; i < NPORT; i++) buf_q[i] <= '0;
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            if (capture[i]) begin
               buf_q[i]  <= bus.in_dev[i*DW +: DW];
               full_q[i] <= 1'b1;
               ack_q[i]  <= 1'b1;
            end else begin
               if (rd_clr[i]) full_q[i] <= 1'b0;
               if (!req_s[i]) ack_q[i]  <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ack  = ack_q;
   assign bus.rd_data = buf_q[bus.in_sel];

`ifdef IO_STATUS_EN
   assign bus.status[ST_OVR_LSB  +: NPORT] = overrun;
   assign bus.status[ST_BUSY_LSB +: NPORT] = out_busy;
   assign bus.status[ST_FULL_LSB +: NPORT] = full_q;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed handshake scenarios plus randomized
// write/capture traffic against a transaction-level model of the ports.
// Optional feature macro: IO_STATUS_EN (also checks status and clr_ovr).
module tb_io_port_bank;

   localparam int DW      = 8;
   localparam int NPORT   = 4;
   localparam int SYNC_FF = 2;
   localparam int LAT_IN  = SYNC_FF + 1;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [DW-1:0]    exp_out [NPORT];
   logic [DW-1:0]    exp_buf [NPORT];
   logic [NPORT-1:0] exp_ovr;

   io_port_bank_if #(.DW(DW), .NPORT(NPORT)) bus ();

   io_port_bank #(
      .DW      (DW),
      .NPORT   (NPORT),
      .SYNC_FF (SYNC_FF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [NPORT*DW-1:0] model_out_bus();
      logic [NPORT*DW-1:0] v;
      for (int i = 0; i < NPORT; i++) v[i*DW +: DW] = exp_out[i];
      return v;
   endfunction

   // Device side: acknowledge every pending request until all handshakes close
   task automatic complete_out();
      int n = 0;
      while (n < 40 && bus.out_req !== '0) begin
         bus.out_ack = bus.out_req;
         tick();
         n++;
      end
      bus.out_ack = '0;
      repeat (SYNC_FF + 2) tick();
      checks++;
      if (bus.out_req !== '0) begin
         failures++;
         $display("FAIL out_handshake_timeout out_req=%b required=0000", bus.out_req);
      end
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      bus.wr_en   = '0;
      bus.wr_data = '0;
      bus.out_ack = '0;
      bus.in_sel  = '0;
      bus.in_rd   = 1'b0;
      bus.in_dev  = '0;
      bus.in_req  = '0;
`ifdef IO_STATUS_EN
      bus.clr_ovr = 1'b0;
`endif
      repeat (2) tick();
      reset = 1'b1;
      tick();
      bus.wr_en            = 4'b0001;
      bus.wr_data          = 8'h5A;
      bus.in_dev[31:24]    = 8'h11;
      bus.in_req[3]        = 1'b1;
      tick();
      bus.wr_en = '0;
      repeat (4) tick();
      bus.out_ack[0] = 1'b1;
      tick();
      reset       = 1'b0;
      bus.in_req  = '0;
      bus.out_ack = '0;
      repeat (2) tick();
      checks++;
      if (bus.out_req !== '0) begin
         failures++;
         $display("FAIL reset_out_req got=%b required=0000", bus.out_req);
      end
      checks++;
      if (bus.in_ack !== '0) begin
         failures++;
         $display("FAIL reset_in_ack got=%b required=0000", bus.in_ack);
      end
      checks++;
      if (bus.out_data !== '0) begin
         failures++;
         $display("FAIL reset_out_data got=%h required=0", bus.out_data);
      end
      for (int s = 0; s < NPORT; s++) begin
         bus.in_sel = 2'(s);
         #1;
         checks++;
         if (bus.rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd_data sel=%0d got=%h required=00", s, bus.rd_data);
         end
      end
`ifdef IO_STATUS_EN
      checks++;
      if (bus.status !== '0) begin
         failures++;
         $display("FAIL reset_status got=%b required=0", bus.status);
      end
`endif
      reset = 1'b1;
      for (int i = 0; i < NPORT; i++) begin
         exp_out[i] = '0;
         exp_buf[i] = '0;
      end
      exp_ovr = '0;
      tick();
   endtask

   task automatic test_out_write();
      bus.wr_en   = 4'b0010;
      bus.wr_data = 8'hA5;
      tick();
      bus.wr_en  = '0;
      exp_out[1] = 8'hA5;
      checks++;
      if (bus.out_data !== model_out_bus()) begin
         failures++;
         $display("FAIL write_data got=%h required=%h", bus.out_data, model_out_bus());
      end
      checks++;
      if (bus.out_req !== 4'b0010) begin
         failures++;
         $display("FAIL write_req got=%b required=0010", bus.out_req);
      end
   endtask

   task automatic test_overrun();
      int n;
      bus.wr_en   = 4'b0010;
      bus.wr_data = 8'h3C;
      tick();
      bus.wr_en = '0;
      checks++;
      if (bus.out_data[15:8] !== 8'hA5) begin
         failures++;
         $display("FAIL overrun_data_kept got=%h required=a5", bus.out_data[15:8]);
      end
      checks++;
      if (bus.out_req !== 4'b0010) begin
         failures++;
         $display("FAIL overrun_req got=%b required=0010", bus.out_req);
      end
`ifdef IO_STATUS_EN
      checks++;
      if (bus.status !== 12'b0010_0010_0000) begin
         failures++;
         $display("FAIL overrun_status got=%b required=001000100000", bus.status);
      end
      bus.clr_ovr = 1'b1;
      tick();
      bus.clr_ovr = 1'b0;
      checks++;
      if (bus.status[11:8] !== 4'b0000) begin
         failures++;
         $display("FAIL clr_ovr got=%b required=0000", bus.status[11:8]);
      end
`endif
      bus.out_ack[1] = 1'b1;
      n = 0;
      while (n < 10 && bus.out_req[1] !== 1'b0) begin
         tick();
         n++;
      end
      checks++;
      if (bus.out_req[1] !== 1'b0) begin
         failures++;
         $display("FAIL ack_drops_req got=%b required=0", bus.out_req[1]);
      end
`ifdef IO_STATUS_EN
      checks++;
      if (bus.status[5] !== 1'b1) begin
         failures++;
         $display("FAIL busy_in_release got=%b required=1", bus.status[5]);
      end
`endif
      bus.out_ack[1] = 1'b0;
      repeat (SYNC_FF + 2) tick();
      bus.wr_en   = 4'b0010;
      bus.wr_data = 8'h5A;
      tick();
      bus.wr_en  = '0;
      exp_out[1] = 8'h5A;
      checks++;
      if (bus.out_data !== model_out_bus() || bus.out_req !== 4'b0010) begin
         failures++;
         $display("FAIL rewrite_after_idle data=%h req=%b required data=%h req=0010",
                  bus.out_data, bus.out_req, model_out_bus());
      end
      complete_out();
   endtask

   task automatic test_in_capture();
      int n;
      bus.in_dev[23:16] = 8'h7E;
      bus.in_req[2]     = 1'b1;
      n = 0;
      while (n < 10 && bus.in_ack[2] !== 1'b1) begin
         tick();
         n++;
      end
      checks++;
      if (n != LAT_IN) begin
         failures++;
         $display("FAIL in_ack_latency got=%0d required=%0d", n, LAT_IN);
      end
      exp_buf[2] = 8'h7E;
      bus.in_sel = 2'd2;
      #1;
      checks++;
      if (bus.rd_data !== 8'h7E) begin
         failures++;
         $display("FAIL in_capture_data got=%h required=7e", bus.rd_data);
      end
      checks++;
      if (bus.in_ack !== 4'b0100) begin
         failures++;
         $display("FAIL in_ack_vector got=%b required=0100", bus.in_ack);
      end
`ifdef IO_STATUS_EN
      checks++;
      if (bus.status[3:0] !== 4'b0100) begin
         failures++;
         $display("FAIL in_full_status got=%b required=0100", bus.status[3:0]);
      end
`endif
      bus.in_req[2] = 1'b0;
      n = 0;
      while (n < 10 && bus.in_ack[2] !== 1'b0) begin
         tick();
         n++;
      end
      checks++;
      if (n != LAT_IN) begin
         failures++;
         $display("FAIL in_ack_drop_latency got=%0d required=%0d", n, LAT_IN);
      end
   endtask

   task automatic test_backpressure();
      int n;
      bus.in_dev[23:16] = 8'hC3;
      bus.in_req[2]     = 1'b1;
      repeat (8) tick();
      checks++;
      if (bus.in_ack[2] !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_ack got=%b required=0", bus.in_ack[2]);
      end
      checks++;
      if (bus.rd_data !== 8'h7E) begin
         failures++;
         $display("FAIL backpressure_data got=%h required=7e", bus.rd_data);
      end
      bus.in_rd = 1'b1;
      tick();
      bus.in_rd = 1'b0;
      n = 0;
      while (n < 10 && bus.in_ack[2] !== 1'b1) begin
         tick();
         n++;
      end
      checks++;
      if (n != 1) begin
         failures++;
         $display("FAIL capture_after_clear cycles got=%0d required=1", n);
      end
      exp_buf[2] = 8'hC3;
      checks++;
      if (bus.rd_data !== exp_buf[2]) begin
         failures++;
         $display("FAIL second_word got=%h required=%h", bus.rd_data, exp_buf[2]);
      end
      bus.in_rd = 1'b1;
      tick();
      bus.in_req[2] = 1'b0;
      tick();
      bus.in_rd = 1'b0;
      repeat (LAT_IN + 1) tick();
      checks++;
      if (bus.rd_data !== exp_buf[2] || bus.in_ack[2] !== 1'b0) begin
         failures++;
         $display("FAIL read_empty data=%h ack=%b required data=%h ack=0",
                  bus.rd_data, bus.in_ack[2], exp_buf[2]);
      end
   endtask

   task automatic test_random();
      logic [NPORT-1:0] mask, mask2, busy_m, accept;
      logic [DW-1:0]    d1, d2, d;
      int               p, q, n;
      for (int it = 0; it < 12; it++) begin
         mask        = 4'($urandom_range(1, 15));
         d1          = 8'($urandom);
         bus.wr_en   = mask;
         bus.wr_data = d1;
         tick();
         bus.wr_en = '0;
         for (int i = 0; i < NPORT; i++) if (mask[i]) exp_out[i] = d1;
         busy_m = mask;
         checks++;
         if (bus.out_data !== model_out_bus() || bus.out_req !== busy_m) begin
            failures++;
            $display("FAIL rand_write it=%0d data=%h req=%b required data=%h req=%b",
                     it, bus.out_data, bus.out_req, model_out_bus(), busy_m);
         end
         mask2       = 4'($urandom_range(0, 15));
         d2          = 8'($urandom);
         bus.wr_en   = mask2;
         bus.wr_data = d2;
         tick();
         bus.wr_en = '0;
         accept  = mask2 & ~busy_m;
         exp_ovr = exp_ovr | (mask2 & busy_m);
         for (int i = 0; i < NPORT; i++) if (accept[i]) exp_out[i] = d2;
         busy_m = busy_m | accept;
         checks++;
         if (bus.out_data !== model_out_bus() || bus.out_req !== busy_m) begin
            failures++;
            $display("FAIL rand_write_busy it=%0d data=%h req=%b required data=%h req=%b",
                     it, bus.out_data, bus.out_req, model_out_bus(), busy_m);
         end
`ifdef IO_STATUS_EN
         checks++;
         if (bus.status[11:4] !== {exp_ovr, busy_m}) begin
            failures++;
            $display("FAIL rand_status it=%0d got=%b required=%b",
                     it, bus.status[11:4], {exp_ovr, busy_m});
         end
         bus.clr_ovr = 1'b1;
         tick();
         bus.clr_ovr = 1'b0;
`endif
         exp_ovr = '0;
         complete_out();

         p = $urandom_range(0, NPORT - 1);
         d = 8'($urandom);
         bus.in_dev[p*DW +: DW] = d;
         bus.in_req[p]          = 1'b1;
         n = 0;
         while (n < 10 && bus.in_ack[p] !== 1'b1) begin
            tick();
            n++;
         end
         exp_buf[p] = d;
         checks++;
         if (n != LAT_IN) begin
            failures++;
            $display("FAIL rand_in_latency it=%0d port=%0d got=%0d required=%0d",
                     it, p, n, LAT_IN);
         end
         q = $urandom_range(0, NPORT - 1);
         bus.in_sel = 2'(q);
         #1;
         checks++;
         if (bus.rd_data !== exp_buf[q]) begin
            failures++;
            $display("FAIL rand_rd it=%0d sel=%0d got=%h required=%h",
                     it, q, bus.rd_data, exp_buf[q]);
         end
         bus.in_sel = 2'(p);
         bus.in_rd  = 1'b1;
         tick();
         bus.in_rd     = 1'b0;
         bus.in_req[p] = 1'b0;
         n = 0;
         while (n < 10 && bus.in_ack[p] !== 1'b0) begin
            tick();
            n++;
         end
         checks++;
         if (bus.in_ack[p] !== 1'b0) begin
            failures++;
            $display("FAIL rand_ack_drop it=%0d port=%0d got=1 required=0", it, p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_out_write();
      test_overrun();
      test_in_capture();
      test_backpressure();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
